// File: rtl/dbus_lock_arbiter.sv
// dbus_lock_arbiter: two-master data-bus arbiter with AMO bus lock,
// lock watchdog and master-1 write snoop of the LR reservation.
module dbus_lock_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic                m0_lock,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_sel,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  input  logic                resv_valid_i,
  input  logic [ADDR_W-1:0]   resv_addr_i,
  output logic                resv_clr_o,
  output logic                lock_err_o
);

  localparam int CW = $clog2(LOCK_MAX) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          lock_kill_q, lock_kill_d;
  logic          resv_clr_q, resv_clr_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic busy;
  logic own_req;
  logic lock_eff;
  logic cnt_hit;
  logic addr_hit;
  logic unused_resv_lsb;

  assign busy     = (state_q == BUSY);
  assign own_req  = owner_q ? m1_req : m0_req;
  assign lock_eff = m0_lock & ~lock_kill_q;
  assign cnt_hit  = (lock_cnt_q == CNT_MAX);
  assign addr_hit = (m1_addr[ADDR_W-1:2]
                     == resv_addr_i[ADDR_W-1:2]);
  assign unused_resv_lsb = ^resv_addr_i[1:0];
  assign resv_clr_o = resv_clr_q;

  // Owner's group drives the bus only while BUSY; all else is zero.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_sel   = '0;
    m0_ack    = 1'b0;
    m0_rdata  = '0;
    m1_ack    = 1'b0;
    m1_rdata  = '0;
    if (busy) begin
      bus_req = own_req;
      if (owner_q) begin
        bus_we    = m1_we;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        bus_sel   = m1_sel;
        m1_ack    = bus_ack;
        m1_rdata  = bus_rdata;
      end else begin
        bus_we    = m0_we;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        bus_sel   = m0_sel;
        m0_ack    = bus_ack;
        m0_rdata  = bus_rdata;
      end
    end
  end

  // Arbitration, lock tracking, watchdog and snoop next-state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_kill_d = lock_kill_q & m0_lock;
    lock_err_o  = 1'b0;
    lock_cnt_d  = '0;
    resv_clr_d  = busy & owner_q & bus_ack & m1_we
                  & resv_valid_i & addr_hit;
    if (state_q == LOCKED || (busy && !owner_q && lock_eff))
      lock_cnt_d = cnt_hit ? lock_cnt_q : lock_cnt_q + CW'(1);
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = BUSY;
          owner_d = (m0_req && m1_req) ? rr_ptr_q : m1_req;
        end
      end
      BUSY: begin
        if (!own_req) begin
          state_d = IDLE;
        end else if (bus_ack) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
          if (!owner_q && lock_eff) begin
            if (cnt_hit) begin
              lock_err_o  = 1'b1;
              lock_kill_d = 1'b1;
            end else begin
              state_d = LOCKED;
            end
          end
        end
      end
      LOCKED: begin
        if (cnt_hit) begin
          state_d     = IDLE;
          lock_err_o  = 1'b1;
          lock_kill_d = 1'b1;
        end else if (m0_req) begin
          state_d = BUSY;
          owner_d = 1'b0;
        end else if (!m0_lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      lock_kill_q <= 1'b0;
      resv_clr_q  <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_kill_q <= lock_kill_d;
      resv_clr_q  <= resv_clr_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

endmodule

// File: doc/dbus_lock_arbiter.md
Name: dbus_lock_arbiter

Overview:
- Two-master arbiter in front of the single data-bus port.
- Master 0 is the core LSU, including AMO load/store sequences. Master 1 is a secondary master (debug/DMA).
- Master 0 can lock the bus across an AMO read-modify-write so master 1 cannot intervene.
- The block snoops master-1 writes to clear the LR/SC reservation, and a watchdog breaks runaway locks.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_MAX, 16, maximum consecutive cycles master 0 may hold the lock (counts LOCKED and locked BUSY cycles).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_sel  in  DATA_W/8  master 0 byte select.
- m0_lock  in  1  master 0 bus lock (high from AMO load request until AMO store ack).
- m0_rdata  out  DATA_W  master 0 read data.
- m0_ack  out  1  master 0 acknowledge.
- m1_req, m1_we, m1_addr, m1_wdata, m1_sel  in  1/1/ADDR_W/DATA_W/DATA_W/8  master 1 request group; same meanings as master 0.
- m1_rdata  out  DATA_W  master 1 read data.
- m1_ack  out  1  master 1 acknowledge.
- bus_req, bus_we, bus_addr, bus_wdata, bus_sel  out  1/1/ADDR_W/DATA_W/DATA_W/8  downstream request group.
- bus_rdata  in  DATA_W  downstream read data.
- bus_ack  in  1  downstream single-cycle acknowledge.
- resv_valid_i  in  1  LR reservation active.
- resv_addr_i  in  ADDR_W  reserved address.
- resv_clr_o  out  1  one-cycle reservation-clear pulse.
- lock_err_o  out  1  one-cycle lock watchdog pulse.

Behaviour:
- **State machine states:** IDLE, BUSY, LOCKED. Registered signals: owner (0/1), rr_ptr, lock_cnt, lock_kill.
- **Reset values:** state=IDLE, owner=0, rr_ptr=0 (master 0 preferred), lock_cnt=0, lock_kill=0. All outputs 0 during and after reset.
- **IDLE:**
  - Only m0_req: owner=0, go to BUSY.
  - Only m1_req: owner=1, go to BUSY.
  - Both requesting: owner=rr_ptr, go to BUSY.
  - No request: stay in IDLE.
  - bus_req=0 in IDLE.
- **Latency:** a request seen in IDLE at cycle N gives bus_req=1 at cycle N+1.
- **BUSY:**
  - bus_req/we/addr/wdata/sel are a combinational mux of the owner's group; bus_req = owner's req.
  - Owner's ack = bus_ack and owner's rdata = bus_rdata. Non-owner ack=0 and rdata=0 at all times.
- **On bus_ack in BUSY:**
  - rr_ptr becomes the non-owner.
  - If owner=0 and m0_lock=1 and lock_kill=0: go to LOCKED.
  - Otherwise: go to IDLE.
  - No back-to-back grant in the same cycle; the next arbitration happens in IDLE or LOCKED.
- **LOCKED:**
  - bus_req=0; master 1 is never granted.
  - m0_req=1: owner=0, go to BUSY.
  - m0_lock=0: go to IDLE.
  - m0_req has priority when both m0_req=1 and m0_lock=0.
- **Lock watchdog:**
  - lock_cnt increments each cycle state is LOCKED, or BUSY with owner=0 and m0_lock=1.
  - lock_cnt clears otherwise.
  - If lock_cnt reaches LOCK_MAX-1 while LOCKED: force IDLE, pulse lock_err_o one cycle, set lock_kill.
  - If the limit is hit while BUSY: complete the transfer, then go to IDLE (not LOCKED), pulse lock_err_o at that ack.
  - lock_kill makes m0_lock ignored until m0_lock is sampled 0, then lock_kill clears.
- **Master 1 lock:** master 1 has no lock; it is always released after each transfer.
- **Reservation snoop:**
  - Condition at cycle N: bus_ack, owner=1, m1_we=1, resv_valid_i=1, and addr[ADDR_W-1:2] of m1_addr equals that of resv_addr_i.
  - Response: resv_clr_o=1 at cycle N+1, for one cycle. Byte select is ignored.
  - Master-0 writes never assert resv_clr_o; the AMO unit handles its own reservation.
- **Protocol rules:**
  - Masters hold request fields stable until ack.
  - If the owner drops req in BUSY without ack, go to IDLE next cycle and rr_ptr is unchanged.
  - The downstream slave never acks when bus_req=0; any stray bus_ack in IDLE/LOCKED is ignored.
- **Reset mid-transfer:** asynchronous return to IDLE; no ack is forwarded.

Test Plan:
1. **Master 0 alone:** m0 read to 0x100, slave acks 2 cycles after bus_req with rdata 0xDEADBEEF -> bus_req rises 1 cycle after m0_req; m0_ack=1 with m0_rdata=0xDEADBEEF; m1_ack=0.
2. **Round-robin:** both masters request continuously -> grants alternate m0, m1, m0, m1 starting with m0 after reset; IDLE cycle between each.
3. **Atomic lock:** m0 locked load to 0x200, m1_req raised during the load, m0 store to 0x200 three cycles after the load ack, then lock dropped -> m1 is not granted until after the m0 store ack; bus sequence is m0 load, m0 store, m1 access.
4. **Reservation snoop:** resv_valid_i=1, resv_addr_i=0x300, m1 write to 0x302 -> resv_clr_o pulses one cycle after ack. Same write to 0x304 -> no pulse. m1 read to 0x300 -> no pulse.
5. **Watchdog:** LOCK_MAX=4, m0_lock held with no further m0_req -> lock_err_o pulses; state returns to IDLE; pending m1_req is granted next cycle; m0_lock ignored until deasserted.
6. **Mid-transfer reset:** rst_n asserted while BUSY for m1 -> all outputs 0 immediately; after release, m0 and m1 requesting together -> m0 granted first.
